// File: rtl/matmul_job_scheduler_pkg.sv
// Shared definitions for the matmul job scheduler: FSM encodings and port-B ownership.
package matmul_job_scheduler_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StGrant   = 3'd1;
    localparam logic [2:0] StStart   = 3'd2;
    localparam logic [2:0] StRun     = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    // Memory port B belongs to the engine from GRANT through RUN.
    function automatic logic engine_owns_port(input logic [2:0] state);
        return (state == StGrant) || (state == StStart) || (state == StRun);
    endfunction

endpackage

// File: rtl/matmul_job_scheduler_job_fifo.sv
// Show-ahead descriptor FIFO with full/empty flags and an occupancy count.
module matmul_job_scheduler_job_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count
);

    localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wptr_q;
    logic [DEPTH_LOG-1:0] rptr_q;
    logic [DEPTH_LOG:0]   count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Queues matmul job descriptors, validates them, and launches them one at a time on the
// engine under a watchdog. Owns is_working, which steers memory port B to the engine.
module matmul_job_scheduler
    import matmul_job_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned MAX_LEN     = 100,
    parameter int unsigned MAX_LEN_LOG = 7,
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned QDEPTH_LOG  = 2,
    parameter int unsigned TO_W        = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [ADDR_WIDTH-1:0]   job_a_base,
    input  logic [ADDR_WIDTH-1:0]   job_b_base,
    input  logic [ADDR_WIDTH-1:0]   job_c_base,
    input  logic [MAX_LEN_LOG-1:0]  job_m,
    input  logic [MAX_LEN_LOG-1:0]  job_n,
    input  logic [MAX_LEN_LOG-1:0]  job_p,
    output logic                    eng_start,
    output logic                    eng_abort,
    output logic [ADDR_WIDTH-1:0]   eng_a_base,
    output logic [ADDR_WIDTH-1:0]   eng_b_base,
    output logic [ADDR_WIDTH-1:0]   eng_c_base,
    output logic [MAX_LEN_LOG-1:0]  eng_m,
    output logic [MAX_LEN_LOG-1:0]  eng_n,
    output logic [MAX_LEN_LOG-1:0]  eng_p,
    input  logic                    eng_done,
    output logic                    is_working,
    output logic                    job_done,
    output logic                    job_err,
    output logic                    result_ready,
    output logic [QDEPTH_LOG:0]     q_count
);

    localparam int unsigned DESC_W = 3 * ADDR_WIDTH + 3 * MAX_LEN_LOG;
    localparam int unsigned CHK_W  = ADDR_WIDTH + 2 * MAX_LEN_LOG;
    localparam int unsigned OFF_B  = ADDR_WIDTH;
    localparam int unsigned OFF_C  = 2 * ADDR_WIDTH;
    localparam int unsigned OFF_M  = 3 * ADDR_WIDTH;
    localparam int unsigned OFF_N  = OFF_M + MAX_LEN_LOG;
    localparam int unsigned OFF_P  = OFF_N + MAX_LEN_LOG;

    localparam logic [MAX_LEN_LOG-1:0] MAX_DIM = MAX_LEN_LOG'(MAX_LEN);
    localparam logic [CHK_W-1:0]       C_LIMIT = CHK_W'(1) << ADDR_WIDTH;
    localparam logic [TO_W-1:0]        WD_MAX  = '1;

    logic [DESC_W-1:0] fifo_wdata;
    logic [DESC_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic [CHK_W-1:0]  c_end;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [TO_W-1:0]   wd_q;
    logic [TO_W-1:0]   wd_d;
    logic              done_d;
    logic              timeout;
    logic              done_seen_q;

    assign job_ready  = !fifo_full;
    assign accept     = job_valid && job_ready;
    assign push       = accept && legal;
    assign fifo_wdata = {job_p, job_n, job_m, job_c_base, job_b_base, job_a_base};

    // Legality: every dimension in 1..MAX_LEN and C fits in memory, computed without truncation.
    always_comb begin
        c_end = CHK_W'(job_c_base) + CHK_W'(job_m) * CHK_W'(job_p);
        legal = (job_m != '0) && (job_m <= MAX_DIM) &&
                (job_n != '0) && (job_n <= MAX_DIM) &&
                (job_p != '0) && (job_p <= MAX_DIM) &&
                (c_end <= C_LIMIT);
    end

    matmul_job_scheduler_job_fifo #(
        .WIDTH     (DESC_W),
        .DEPTH     (QDEPTH),
        .DEPTH_LOG (QDEPTH_LOG)
    ) u_job_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    // Next-state, pop and watchdog logic for the launch sequence.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: state_d = StStart;
            StStart: begin
                // Counter holds the number of RUN cycles including the current one.
                state_d = StRun;
                wd_d    = TO_W'(1);
            end
            StRun: begin
                if (eng_done) begin
                    state_d = StRelease;
                    done_d  = 1'b1;
                end else if (wd_q == WD_MAX) begin
                    state_d = StRelease;
                    timeout = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StRelease: begin
                // RELEASE is the single host cycle between jobs; launch straight away if queued.
                wd_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StGrant;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, watchdog, registered pulses and the latched descriptor of the current job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wd_q        <= '0;
            job_done    <= 1'b0;
            eng_abort   <= 1'b0;
            job_err     <= 1'b0;
            done_seen_q <= 1'b0;
            eng_a_base  <= '0;
            eng_b_base  <= '0;
            eng_c_base  <= '0;
            eng_m       <= '0;
            eng_n       <= '0;
            eng_p       <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            job_done    <= done_d;
            eng_abort   <= timeout;
            job_err     <= timeout || (accept && !legal);
            done_seen_q <= done_seen_q || done_d;
            if (pop) begin
                eng_a_base <= fifo_rdata[0 +: ADDR_WIDTH];
                eng_b_base <= fifo_rdata[OFF_B +: ADDR_WIDTH];
                eng_c_base <= fifo_rdata[OFF_C +: ADDR_WIDTH];
                eng_m      <= fifo_rdata[OFF_M +: MAX_LEN_LOG];
                eng_n      <= fifo_rdata[OFF_N +: MAX_LEN_LOG];
                eng_p      <= fifo_rdata[OFF_P +: MAX_LEN_LOG];
            end
        end
    end

    assign eng_start    = (state_q == StStart);
    assign is_working   = engine_owns_port(state_q);
    assign result_ready = done_seen_q && fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler with a job-level timeline model checked every cycle.
module tb_matmul_job_scheduler;

    localparam int AW   = 12;
    localparam int ML   = 7;
    localparam int MAXL = 100;
    localparam int QD   = 4;
    localparam int QL   = 2;
    localparam int TW   = 6;
    localparam int RUN_LIMIT = (1 << TW) - 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
        logic [ML-1:0] m;
        logic [ML-1:0] n;
        logic [ML-1:0] p;
    } desc_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [AW-1:0] job_a_base = '0, job_b_base = '0, job_c_base = '0;
    logic [ML-1:0] job_m = '0, job_n = '0, job_p = '0;
    logic          eng_start, eng_abort;
    logic [AW-1:0] eng_a_base, eng_b_base, eng_c_base;
    logic [ML-1:0] eng_m, eng_n, eng_p;
    logic          eng_done = 1'b0;
    logic          is_working, job_done, job_err, result_ready;
    logic [QL:0]   q_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    matmul_job_scheduler #(
        .ADDR_WIDTH (AW), .MAX_LEN (MAXL), .MAX_LEN_LOG (ML),
        .QDEPTH (QD), .QDEPTH_LOG (QL), .TO_W (TW)
    ) dut (
        .clk (clk), .reset (reset),
        .job_valid (job_valid), .job_ready (job_ready),
        .job_a_base (job_a_base), .job_b_base (job_b_base), .job_c_base (job_c_base),
        .job_m (job_m), .job_n (job_n), .job_p (job_p),
        .eng_start (eng_start), .eng_abort (eng_abort),
        .eng_a_base (eng_a_base), .eng_b_base (eng_b_base), .eng_c_base (eng_c_base),
        .eng_m (eng_m), .eng_n (eng_n), .eng_p (eng_p),
        .eng_done (eng_done), .is_working (is_working),
        .job_done (job_done), .job_err (job_err),
        .result_ready (result_ready), .q_count (q_count)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // ---------------- model: job timeline expressed as cycle stamps ----------------
    desc_t mq[$];
    desc_t cur, md;
    bit    m_act, m_acc, m_lg, m_seen, m_rej, m_done, m_to, mdl_on;
    int    m_tg, m_te, m_n, m_k;

    function automatic bit legal_desc(input desc_t d);
        int m = int'(d.m);
        int n = int'(d.n);
        int p = int'(d.p);
        return m >= 1 && m <= MAXL && n >= 1 && n <= MAXL && p >= 1 && p <= MAXL &&
               (int'(d.c) + m * p) <= (1 << AW);
    endfunction

    // m_n is the index of the cycle that just ended; m_tg is the grant cycle of the current job,
    // its RUN cycles start at m_tg+2, and m_te is its release cycle (-1 while unknown).
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            m_act = 0; m_te = -1; m_tg = 0; m_seen = 0;
            m_rej = 0; m_done = 0; m_to = 0; m_n = 0;
        end else begin
            m_acc = job_valid && (mq.size() < QD);
            md = '{a: job_a_base, b: job_b_base, c: job_c_base, m: job_m, n: job_n, p: job_p};
            m_lg = legal_desc(md);
            m_done = 0;
            m_to = 0;
            if (m_act && m_te < 0) begin
                m_k = m_n - (m_tg + 2) + 1;
                if (m_k >= 1) begin
                    if (eng_done) begin
                        m_te = m_n + 1; m_done = 1;
                    end else if (m_k == RUN_LIMIT) begin
                        m_te = m_n + 1; m_to = 1;
                    end
                end
            end
            if (!m_act || m_te == m_n) begin
                m_act = 0;
                if (mq.size() > 0) begin
                    cur = mq.pop_front();
                    m_act = 1; m_tg = m_n + 1; m_te = -1;
                end
            end
            if (m_acc && m_lg) mq.push_back(md);
            m_rej = m_acc && !m_lg;
            m_seen = m_seen || m_done;
            m_n = m_n + 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset && mdl_on) begin
            chk("job_ready", job_ready, mq.size() < QD);
            chk("q_count", q_count, mq.size());
            chk("is_working", is_working, m_act && (m_te != m_n));
            chk("eng_start", eng_start, m_act && (m_n == m_tg + 1));
            chk("job_done", job_done, m_done);
            chk("eng_abort", eng_abort, m_to);
            chk("job_err", job_err, m_to || m_rej);
            chk("result_ready", result_ready, m_seen && mq.size() == 0 && !m_act);
            if (m_act) begin
                chk("eng_a_base", eng_a_base, cur.a);
                chk("eng_b_base", eng_b_base, cur.b);
                chk("eng_c_base", eng_c_base, cur.c);
                chk("eng_mnp", {eng_m, eng_n, eng_p}, {cur.m, cur.n, cur.p});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input int a, input int b, input int c, input int m, input int n,
                         input int p, output bit took);
        job_a_base = AW'(a); job_b_base = AW'(b); job_c_base = AW'(c);
        job_m = ML'(m); job_n = ML'(n); job_p = ML'(p);
        job_valid = 1'b1;
        took = job_ready;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_start(output int s);
        int i = 0;
        while (!eng_start && i < 300) begin
            tick();
            i++;
        end
        if (!eng_start) chk("eng_start_timeout", 0, 1);
        s = cyc;
    endtask

    task automatic pulse_done(output int d);
        eng_done = 1'b1;
        d = cyc;
        tick();
        eng_done = 1'b0;
    endtask

    task automatic done_after(input int s, input int delay, output int d);
        while (cyc < s + delay) tick();
        pulse_done(d);
    endtask

    initial begin
        bit took;
        int t, s, s2, d, acyc, i;

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        mdl_on = 1'b1;

        // Reset values.
        chk("rst_job_ready", job_ready, 1);
        chk("rst_is_working", is_working, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_result_ready", result_ready, 0);
        chk("rst_eng_a_base", eng_a_base, 0);

        // 1: single legal job, done 50 cycles after start.
        offer(0, 16, 32, 4, 4, 4, took);
        t = cyc;
        wait_start(s);
        chk("t1_start_latency", s - t, 2);
        done_after(s, 50, d);
        chk("t1_job_done", job_done, 1);
        chk("t1_is_working", is_working, 0);
        tick();
        chk("t1_result_ready", result_ready, 1);

        // 2: fill the queue behind a stalled job, then drain in order.
        offer(50, 60, 70, 2, 2, 2, took);
        wait_start(s);
        for (int j = 0; j < 4; j++) offer(100 * (j + 1), 900, 1000 + 8 * j, 2, 3, 2, took);
        chk("t2_q_count_full", q_count, 4);
        chk("t2_job_ready_full", job_ready, 0);
        offer(500, 900, 1100, 2, 3, 2, took);
        chk("t2_full_refused", took, 0);
        chk("t2_q_count_hold", q_count, 4);
        pulse_done(d);
        for (int j = 0; j < 5; j++) begin
            wait_start(s);
            chk("t2_gap", s - d, 3);
            chk("t2_order", eng_a_base, 100 * (j + 1));
            if (j == 0) begin
                offer(500, 900, 1100, 2, 3, 2, took);
                chk("t2_fifth_taken", took, 1);
            end
            done_after(s, 5, d);
        end
        repeat (2) tick();

        // 3: illegal descriptors, a stray eng_done, and a boundary-legal one.
        offer(0, 0, 0, 0, 4, 4, took);
        chk("t3_m0_err", job_err, 1);
        chk("t3_m0_q", q_count, 0);
        offer(0, 0, 0, 4, 4, 101, took);
        chk("t3_p101_err", job_err, 1);
        offer(0, 0, 4090, 4, 4, 4, took);
        chk("t3_cover_err", job_err, 1);
        chk("t3_cover_q", q_count, 0);
        pulse_done(d);
        tick();
        chk("t3_idle_done_ignored", is_working, 0);
        offer(0, 0, 4080, 4, 4, 4, took);
        tick();
        chk("t3_boundary_err", job_err, 0);
        wait_start(s);
        done_after(s, 3, d);
        chk("t3_boundary_done", job_done, 1);
        repeat (2) tick();

        // 4 and 5: timeout on the first job, done coinciding with expiry on the second.
        offer(200, 16, 32, 3, 3, 3, took);
        offer(300, 16, 64, 3, 3, 3, took);
        wait_start(s);
        i = 0;
        while (!eng_abort && i < 100) begin
            tick();
            i++;
        end
        acyc = cyc;
        chk("t4_abort_cycle", acyc - s, RUN_LIMIT + 1);
        chk("t4_job_err", job_err, 1);
        wait_start(s2);
        chk("t4_next_launch", s2 - acyc, 2);
        chk("t4_next_job", eng_a_base, 300);
        done_after(s2, RUN_LIMIT, d);
        chk("t5_job_done", job_done, 1);
        chk("t5_job_err", job_err, 0);
        chk("t5_eng_abort", eng_abort, 0);
        repeat (2) tick();

        // 6: asynchronous reset during RUN with two jobs queued.
        offer(400, 16, 32, 2, 2, 2, took);
        wait_start(s);
        offer(410, 16, 32, 2, 2, 2, took);
        offer(420, 16, 32, 2, 2, 2, took);
        tick();
        chk("t6_q_before", q_count, 2);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_is_working_async", is_working, 0);
        chk("t6_q_count_async", q_count, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        chk("t6_job_ready", job_ready, 1);
        chk("t6_result_ready", result_ready, 0);
        repeat (10) tick();
        chk("t6_no_err", job_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
